playfield_engine: RTL and testbench

PLAYFIELD_ENGINE -- requirements
Module: playfield_engine

---
 rtl/playfield_engine.sv | 211 +++++++++++++++++++++
 tb/tb_playfield_engine.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_engine.sv
// Playfield engine: board storage, line clearing, garbage-row insertion and
// BCD scoring, sequenced by a piece-lock handshake.
module playfield_engine #(
    parameter int         W         = 10,
    parameter int         H         = 20,
    parameter int         GQ        = 8,
    parameter logic [2:0] GARB_KIND = 3'd0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 restart,
    input  logic                 lock_valid,
    output logic                 lock_ready,
    input  logic [W*H-1:0]       lock_mask,
    input  logic [2:0]           lock_kind,
    input  logic                 garb_valid,
    output logic                 garb_ready,
    input  logic [$clog2(W)-1:0] garb_hole,
    input  logic [4:0]           rd_x,
    input  logic [4:0]           rd_y,
    output logic                 rd_occ,
    output logic [2:0]           rd_kind,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           lines,
    output logic [15:0]          score,
    output logic                 top_out
);
    localparam int N  = W * H;
    localparam int HW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int QA = $clog2(GQ);
    localparam int NB = $clog2(N);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MERGE  = 3'd1;
    localparam logic [2:0] S_SCAN   = 3'd2;
    localparam logic [2:0] S_GARB   = 3'd3;
    localparam logic [2:0] S_SCORE  = 3'd4;
    localparam logic [2:0] S_TOPOUT = 3'd5;

    logic [2:0]    state;
    logic [N-1:0]  occ, occ_n, mask_q;
    logic [2:0]    kind   [N];
    logic [2:0]    kind_n [N];
    logic [2:0]    kind_q;
    logic [YW-1:0] row;
    logic [5:0]    cnt;
    logic [HW-1:0] fifo [GQ];
    logic [QA-1:0] wr_ptr, rd_ptr;
    logic [QA:0]   fcnt;
    logic          fifo_full, fifo_empty, push, pop;
    logic          overlap, row_full, top_occ;
    logic [HW-1:0] hole_in, hole_out;
    logic [3:0]    points;
    logic [NB-1:0] rd_idx;

    function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [3:0] p);
        logic [15:0] r;
        logic [4:0]  d;
        logic        c;
        r = '0;
        c = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} + {4'd0, c};
            if (i == 0) d = d + {1'b0, p};
            c = (d > 5'd9);
            if (c) d = d - 5'd10;
            r[4*i +: 4] = d[3:0];
        end
        return c ? 16'h9999 : r;
    endfunction

    always_comb begin
        fifo_empty = (fcnt == '0);
        fifo_full  = (fcnt == (QA+1)'(GQ));
        top_out    = (state == S_TOPOUT);
        busy       = (state != S_IDLE);
        lock_ready = (state == S_IDLE);
        garb_ready = !fifo_full && !top_out;
        push       = garb_valid && garb_ready && !restart;
        hole_in    = (32'(garb_hole) >= W) ? HW'(W - 1) : garb_hole;
        hole_out   = fifo[rd_ptr];
        top_occ    = |occ[W-1:0];
        overlap    = |(occ & mask_q);
        row_full   = &occ[32'(row)*W +: W];
        pop        = (state == S_GARB) && !fifo_empty && !top_occ && !restart;
        rd_idx     = NB'(32'(rd_y) * W + 32'(rd_x));
        case (cnt)
            6'd0:    points = 4'd0;
            6'd1:    points = 4'd1;
            6'd2:    points = 4'd3;
            6'd3:    points = 4'd5;
            default: points = 4'd8;
        endcase
    end

    always_comb begin
        occ_n  = occ;
        kind_n = kind;
        case (state)
            S_MERGE: if (!overlap) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (mask_q[i]) begin
                        occ_n[i]  = 1'b1;
                        kind_n[i] = kind_q;
                    end
                end
            end
            // rows 1..row take the row above; row 0 always empties on a clear
            S_SCAN: if (row_full) begin
                for (int unsigned y = 1; y < H; y++) begin
                    if (y <= 32'(row)) begin
                        for (int unsigned x = 0; x < W; x++) begin
                            occ_n[y*W+x]  = occ[(y-1)*W+x];
                            kind_n[y*W+x] = kind[(y-1)*W+x];
                        end
                    end
                end
                for (int unsigned x = 0; x < W; x++) begin
                    occ_n[x]  = 1'b0;
                    kind_n[x] = 3'd0;
                end
            end
            S_GARB: if (pop) begin
                for (int unsigned y = 0; y < H - 1; y++) begin
                    for (int unsigned x = 0; x < W; x++) begin
                        occ_n[y*W+x]  = occ[(y+1)*W+x];
                        kind_n[y*W+x] = kind[(y+1)*W+x];
                    end
                end
                for (int unsigned x = 0; x < W; x++) begin
                    occ_n[(H-1)*W+x]  = (x != 32'(hole_out));
                    kind_n[(H-1)*W+x] = (x != 32'(hole_out)) ? GARB_KIND : 3'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= hole_in;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || restart) begin
            state  <= S_IDLE;
            occ    <= '0;
            for (int unsigned i = 0; i < N; i++) kind[i] <= '0;
            mask_q <= '0;
            kind_q <= '0;
            row    <= '0;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
            score  <= '0;
            lines  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            occ  <= occ_n;
            kind <= kind_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fcnt <= fcnt + 1'b1;
            else if (pop && !push) fcnt <= fcnt - 1'b1;
            case (state)
                S_IDLE: if (lock_valid) begin
                    mask_q <= lock_mask;
                    kind_q <= lock_kind;
                    state  <= S_MERGE;
                end
                S_MERGE: begin
                    row   <= YW'(H - 1);
                    cnt   <= '0;
                    state <= overlap ? S_TOPOUT : S_SCAN;
                end
                S_SCAN: begin
                    if (row_full)       cnt   <= cnt + 1'b1;
                    else if (row == '0) state <= S_GARB;
                    else                row   <= row - 1'b1;
                end
                S_GARB: begin
                    if (fifo_empty)   state <= S_SCORE;
                    else if (top_occ) state <= S_TOPOUT;
                end
                S_SCORE: begin
                    score <= bcd_add(score, points);
                    lines <= (cnt > 6'd7) ? 3'd7 : cnt[2:0];
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_occ  <= 1'b0;
            rd_kind <= 3'd0;
        end else if (32'(rd_x) < W && 32'(rd_y) < H) begin
            rd_occ  <= occ[rd_idx];
            rd_kind <= occ[rd_idx] ? kind[rd_idx] : 3'd0;
        end else begin
            rd_occ  <= 1'b0;
            rd_kind <= 3'd0;
        end
    end
endmodule

// File: tb/tb_playfield_engine.sv
// Bench for playfield_engine: vector table, hand-written corner sequences and
// randomized locks checked against a cell-array reference model.
module tb_playfield_engine;
    localparam int         W  = 10;
    localparam int         H  = 20;
    localparam int         GQ = 8;
    localparam int         N  = W * H;
    localparam logic [2:0] GK = 3'd6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0, restart = 1'b0;
    logic          lock_valid = 1'b0, lock_ready;
    logic [N-1:0]  lock_mask = '0;
    logic [2:0]    lock_kind = '0;
    logic          garb_valid = 1'b0, garb_ready;
    logic [3:0]    garb_hole = '0;
    logic [4:0]    rd_x = '0, rd_y = '0;
    logic          rd_occ, busy, done, top_out;
    logic [2:0]    rd_kind, lines;
    logic [15:0]   score;

    playfield_engine #(.W(W), .H(H), .GQ(GQ), .GARB_KIND(GK)) dut (
        .clk(clk), .reset_n(reset_n), .restart(restart),
        .lock_valid(lock_valid), .lock_ready(lock_ready),
        .lock_mask(lock_mask), .lock_kind(lock_kind),
        .garb_valid(garb_valid), .garb_ready(garb_ready), .garb_hole(garb_hole),
        .rd_x(rd_x), .rd_y(rd_y), .rd_occ(rd_occ), .rd_kind(rd_kind),
        .busy(busy), .done(done), .lines(lines), .score(score), .top_out(top_out)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Reference model: plain cell arrays, a hole queue, decimal score.
    int m_occ  [H][W];
    int m_kind [H][W];
    int m_q [$];
    int m_score, m_lines;
    bit m_top;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endfunction

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
    endfunction

    function automatic void model_clear();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                m_occ[y][x] = 0;
                m_kind[y][x] = 0;
            end
        m_q.delete();
        m_score = 0;
        m_lines = 0;
        m_top = 0;
    endfunction

    function automatic void model_lock(input logic [N-1:0] mask, input int k,
                                       output int lat, output bit top);
        int t_occ [H][W];
        int t_kind [H][W];
        int c, g, nr, h, pts;
        bit full, any_top;
        lat = 0;
        top = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (mask[y*W+x] && m_occ[y][x] != 0) top = 1;
        if (top) begin
            m_top = 1;
            return;
        end
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (mask[y*W+x]) begin
                    m_occ[y][x] = 1;
                    m_kind[y][x] = k;
                end
        // drop every full row, keep the others in order packed to the bottom
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                t_occ[y][x] = 0;
                t_kind[y][x] = 0;
            end
        c = 0;
        nr = H - 1;
        for (int y = H - 1; y >= 0; y--) begin
            full = 1;
            for (int x = 0; x < W; x++) if (m_occ[y][x] == 0) full = 0;
            if (full) c++;
            else begin
                for (int x = 0; x < W; x++) begin
                    t_occ[nr][x] = m_occ[y][x];
                    t_kind[nr][x] = m_kind[y][x];
                end
                nr--;
            end
        end
        m_occ = t_occ;
        m_kind = t_kind;
        g = 0;
        while (m_q.size() > 0) begin
            any_top = 0;
            for (int x = 0; x < W; x++) if (m_occ[0][x] != 0) any_top = 1;
            if (any_top) begin
                m_top = 1;
                top = 1;
                return;
            end
            for (int y = 0; y < H - 1; y++)
                for (int x = 0; x < W; x++) begin
                    m_occ[y][x] = m_occ[y+1][x];
                    m_kind[y][x] = m_kind[y+1][x];
                end
            h = m_q.pop_front();
            for (int x = 0; x < W; x++) begin
                m_occ[H-1][x] = (x != h) ? 1 : 0;
                m_kind[H-1][x] = (x != h) ? int'(GK) : 0;
            end
            g++;
        end
        pts = (c == 0) ? 0 : (c == 1) ? 1 : (c == 2) ? 3 : (c == 3) ? 5 : 8;
        m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
        m_lines = (c > 7) ? 7 : c;
        lat = 3 + H + c + g;
    endfunction

    function automatic logic [N-1:0] cells(input int y, input int x0, input int x1);
        logic [N-1:0] m = '0;
        for (int x = x0; x <= x1; x++) m[y*W+x] = 1'b1;
        return m;
    endfunction

    function automatic logic [N-1:0] rows(input int y0, input int y1);
        logic [N-1:0] m = '0;
        for (int y = y0; y <= y1; y++) m |= cells(y, 0, W - 1);
        return m;
    endfunction

    task automatic do_lock(input logic [N-1:0] mask, input logic [2:0] k,
                           input string nm, output int lat);
        int exp_lat;
        bit exp_top, seen;
        model_lock(mask, int'(k), exp_lat, exp_top);
        chk({nm, " lock_ready"}, int'(lock_ready), 1);
        lock_mask = mask;
        lock_kind = k;
        lock_valid = 1'b1;
        @(posedge clk); #1;
        lock_valid = 1'b0;
        if (exp_top) begin
            seen = 0;
            for (int i = 0; i < 60; i++) begin
                @(posedge clk); #1;
                if (done) seen = 1;
            end
            lat = 0;
            chk({nm, " done absent on top-out"}, int'(seen), 0);
            chk({nm, " top_out"}, int'(top_out), 1);
            chk({nm, " lock_ready in top-out"}, int'(lock_ready), 0);
            chk({nm, " garb_ready in top-out"}, int'(garb_ready), 0);
            chk({nm, " busy in top-out"}, int'(busy), 1);
        end else begin
            for (lat = 1; lat <= 200; lat++) begin
                @(posedge clk); #1;
                if (done) break;
            end
            chk({nm, " done latency"}, lat, exp_lat);
            chk({nm, " lines"}, int'(lines), m_lines);
            chk({nm, " score"}, int'(score), to_bcd(m_score));
            chk({nm, " busy after done"}, int'(busy), 0);
        end
    endtask

    task automatic push_garb(input int h, input string nm);
        bit exp = (m_q.size() < GQ) && !m_top;
        garb_hole = 4'(h);
        garb_valid = 1'b1;
        chk({nm, " garb_ready"}, int'(garb_ready), int'(exp));
        if (exp) m_q.push_back((h >= W) ? W - 1 : h);
        @(posedge clk); #1;
        garb_valid = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        model_clear();
    endtask

    task automatic read_cell(input int x, input int y, input string nm, input int eo, input int ek);
        rd_x = 5'(x);
        rd_y = 5'(y);
        @(posedge clk); #1;
        chk($sformatf("%s rd_occ(%0d,%0d)", nm, x, y), int'(rd_occ), eo);
        chk($sformatf("%s rd_kind(%0d,%0d)", nm, x, y), int'(rd_kind), ek);
    endtask

    task automatic check_board(input string nm);
        int bad = 0, fx = -1, fy = -1, eo, ek;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                rd_x = 5'(x);
                rd_y = 5'(y);
                @(posedge clk); #1;
                eo = m_occ[y][x];
                ek = (eo != 0) ? m_kind[y][x] : 0;
                if (int'(rd_occ) != eo || int'(rd_kind) != ek) begin
                    if (bad == 0) begin
                        fx = x;
                        fy = y;
                    end
                    bad++;
                end
            end
        chk($sformatf("%s board cells wrong (first x=%0d y=%0d)", nm, fx, fy), bad, 0);
    endtask

    typedef struct packed {
        logic [N-1:0] mask;
        logic [2:0]   kind;
        logic [2:0]   lines;
        logic [15:0]  score;
        logic [7:0]   lat;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int lat, acc, seen;
        logic [N-1:0] m;

        tbl[0] = '{cells(19, 0, 3), 3'd1, 3'd0, 16'h0000, 8'd23};
        tbl[1] = '{cells(19, 4, 9), 3'd2, 3'd1, 16'h0001, 8'd24};
        tbl[2] = '{rows(18, 19),    3'd3, 3'd2, 16'h0004, 8'd25};
        tbl[3] = '{rows(17, 19),    3'd4, 3'd3, 16'h0009, 8'd26};
        tbl[4] = '{rows(16, 19),    3'd5, 3'd4, 16'h0017, 8'd27};
        tbl[5] = '{rows(10, 19),    3'd7, 3'd7, 16'h0025, 8'd33};
        tbl[6] = '{cells(19, 0, 0), 3'd2, 3'd0, 16'h0025, 8'd23};

        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset lines", int'(lines), 0);
        chk("reset score", int'(score), 0);
        chk("reset top_out", int'(top_out), 0);
        chk("reset rd_occ", int'(rd_occ), 0);
        chk("reset rd_kind", int'(rd_kind), 0);
        chk("reset lock_ready", int'(lock_ready), 1);
        chk("reset garb_ready", int'(garb_ready), 1);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_board("after reset");

        // I piece on the bottom row: 23 edges after the transfer edge (24 counting the handshake cycle)
        do_lock(cells(19, 0, 3), 3'd1, "ipiece", lat);
        chk("ipiece latency", lat, 23);
        read_cell(2, 19, "ipiece", 1, 1);
        read_cell(4, 19, "ipiece", 0, 0);

        do_restart();
        for (int i = 0; i < 7; i++) begin
            do_lock(tbl[i].mask, tbl[i].kind, $sformatf("vec%0d", i), lat);
            chk($sformatf("vec%0d table latency", i), lat, int'(tbl[i].lat));
            chk($sformatf("vec%0d table lines", i), int'(lines), int'(tbl[i].lines));
            chk($sformatf("vec%0d table score", i), int'(score), int'(tbl[i].score));
        end
        check_board("after table");

        // two-line clear: rows 18-19 gain the former rows 16-17
        do_restart();
        m = rows(18, 19) & ~cells(18, 9, 9) & ~cells(19, 9, 9);
        m |= cells(17, 0, 2) | cells(16, 5, 5);
        do_lock(m, 3'd3, "pre2", lat);
        m = cells(16, 9, 9) | cells(17, 9, 9) | cells(18, 9, 9) | cells(19, 9, 9);
        do_lock(m, 3'd4, "two", lat);
        chk("two lines", int'(lines), 2);
        chk("two score", int'(score), 16'h0003);
        chk("two latency", lat, 25);
        read_cell(0, 19, "two", 1, 3);
        read_cell(9, 19, "two", 1, 4);
        read_cell(3, 19, "two", 0, 0);
        read_cell(5, 18, "two", 1, 3);
        read_cell(0, 17, "two", 0, 0);
        read_cell(10, 18, "out of range x", 0, 0);
        read_cell(0, 20, "out of range y", 0, 0);
        check_board("two");

        // garbage queued while idle lands only during the next lock
        do_restart();
        for (int i = 0; i < 3; i++) push_garb(4, "g3");
        repeat (5) @(posedge clk);
        #1;
        read_cell(0, 19, "garb idle", 0, 0);
        do_lock(cells(15, 0, 1), 3'd2, "g3", lat);
        chk("g3 latency", lat, 26);
        read_cell(4, 19, "g3", 0, 0);
        read_cell(0, 19, "g3", 1, int'(GK));
        read_cell(4, 17, "g3", 0, 0);
        read_cell(0, 12, "g3", 1, 2);
        do_lock(cells(5, 0, 0), 3'd1, "g3 fifo empty", lat);
        chk("g3 fifo empty latency", lat, 23);
        check_board("g3");

        do_restart();
        push_garb(12, "clamp");
        do_lock(cells(10, 0, 0), 3'd5, "clamp", lat);
        read_cell(9, 19, "clamp", 0, 0);
        read_cell(8, 19, "clamp", 1, int'(GK));

        // valid held for GQ+1 cycles: only GQ rows accepted
        do_restart();
        acc = 0;
        garb_valid = 1'b1;
        for (int i = 0; i <= GQ; i++) begin
            garb_hole = 4'(i);
            if (garb_ready) acc++;
            if (i < GQ) m_q.push_back(i);
            @(posedge clk); #1;
        end
        garb_valid = 1'b0;
        chk("fifo accepted", acc, GQ);
        chk("fifo full ready", int'(garb_ready), 0);
        do_lock(cells(15, 2, 4), 3'd3, "fifo8", lat);
        chk("fifo8 latency", lat, 31);
        chk("fifo8 ready after drain", int'(garb_ready), 1);
        check_board("fifo8");

        // overlap -> top-out, then restart
        do_restart();
        do_lock(cells(19, 0, 3), 3'd1, "ovl pre", lat);
        do_lock(cells(19, 3, 5), 3'd2, "ovl", lat);
        push_garb(1, "ovl push");
        check_board("ovl frozen");
        do_restart();
        chk("restart top_out", int'(top_out), 0);
        chk("restart busy", int'(busy), 0);
        chk("restart lock_ready", int'(lock_ready), 1);
        chk("restart score", int'(score), 0);
        check_board("restart");

        // restart wins over a same-cycle lock handshake
        lock_mask = cells(19, 0, 9);
        lock_kind = 3'd2;
        lock_valid = 1'b1;
        restart = 1'b1;
        @(posedge clk); #1;
        lock_valid = 1'b0;
        restart = 1'b0;
        chk("restart vs lock busy", int'(busy), 0);
        check_board("restart vs lock");

        // reset mid-sequence: no done, no score
        do_lock(rows(19, 19), 3'd1, "pre reset", lat);
        lock_mask = rows(19, 19);
        lock_kind = 3'd3;
        lock_valid = 1'b1;
        @(posedge clk); #1;
        lock_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_clear();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("reset mid no done", seen, 0);
        chk("reset mid score", int'(score), 0);
        chk("reset mid busy", int'(busy), 0);
        check_board("reset mid");

        // randomized locks with garbage
        do_restart();
        for (int it = 0; it < 40; it++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                push_garb(int'($urandom_range(0, 15)), $sformatf("rnd%0d push", it));
            m = '0;
            if ($urandom_range(0, 9) == 0) begin
                for (int y = H - 1; y >= 0 && m == '0; y--)
                    for (int x = 0; x < W; x++)
                        if (m == '0 && m_occ[y][x] != 0) m[y*W+x] = 1'b1;
            end
            if (m == '0) begin
                for (int y = H - 4; y < H; y++) begin
                    seen = ($urandom_range(0, 2) == 0) ? 1 : 0;
                    for (int x = 0; x < W; x++)
                        if (m_occ[y][x] == 0 && (seen == 1 || $urandom_range(0, 3) == 0))
                            m[y*W+x] = 1'b1;
                end
            end
            do_lock(m, 3'($urandom_range(1, 7)), $sformatf("rnd%0d", it), lat);
            check_board($sformatf("rnd%0d", it));
            if (m_top) do_restart();
        end

        // score saturation
        do_restart();
        for (int i = 0; i < 1249; i++) do_lock(rows(16, 19), 3'd1, "sat run", lat);
        do_lock(rows(17, 19), 3'd2, "sat 9997", lat);
        chk("score 9997", int'(score), 16'h9997);
        do_lock(rows(16, 19), 3'd3, "sat tetris", lat);
        chk("score saturated", int'(score), 16'h9999);
        chk("sat lines", int'(lines), 4);
        do_lock(rows(19, 19), 3'd4, "sat single", lat);
        chk("score stays saturated", int'(score), 16'h9999);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
